stopwatch_controller: RTL and testbench

Front-end sequencer for the stopwatch BCD counter chain (min/s/centisecond digits). It synchronises and debounces the two active-low push buttons and runs the start/pause/lap/clear state machine. It also divides the system clock into the one-cycle count tick that advances the counter, and drives the counter's clear and the display-hold control.

---
 rtl/stopwatch_controller.sv | 129 ++++++++++++
 tb/tb_stopwatch_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_controller.sv
// stopwatch_controller: button synchronisers and debouncers, the
// start/pause/lap/clear sequencer, and the count-tick prescaler that
// drive the stopwatch BCD counter chain.
module stopwatch_controller #(
    parameter int CLK_DIV         = 500000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int DB_W            = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_pause,
    input  logic       lap_clear,
    output logic       tick,
    output logic       clear,
    output logic       running,
    output logic       display_hold,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        LAP     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

    // Button index 0 is start_pause, index 1 is lap_clear; level 1 = released.
    logic [1:0]      btn_p0;
    logic [1:0]      btn_p1;
    logic [1:0]      acc_p2;
    logic [DB_W-1:0] db_cnt_p2 [2];
    logic [1:0]      press_p2;

    state_t           st_p3;
    state_t           st_nxt;
    logic [CNT_W-1:0] presc_p3;

    // Next state on press events; start_pause takes priority over lap_clear.
    function automatic state_t fsm_next(input state_t cur, input logic sp, input logic lap);
        state_t nxt;
        nxt = cur;
        case (cur)
            IDLE:    if (sp) nxt = RUNNING;
            RUNNING: if (sp) nxt = PAUSED; else if (lap) nxt = LAP;
            LAP:     if (sp) nxt = PAUSED; else if (lap) nxt = RUNNING;
            PAUSED:  if (sp) nxt = RUNNING; else if (lap) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

    function automatic logic is_counting(input state_t s);
        return (s == RUNNING) || (s == LAP);
    endfunction

    assign st_nxt = fsm_next(st_p3, press_p2[0], press_p2[1]);
    assign state  = st_p3;

    // Two-flop synchronisers for the asynchronous raw buttons (idle high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_p0 <= 2'b11;
            btn_p1 <= 2'b11;
        end else begin
            btn_p0 <= {lap_clear, start_pause};
            btn_p1 <= btn_p0;
        end
    end

    // ---- stage p2: debounce; accept a level after DEBOUNCE_CYCLES differing samples
    // Debouncers: count disagreement with the accepted level, flip on the last one,
    // and pulse a press event only on the flip to pressed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_p2   <= 2'b11;
            press_p2 <= 2'b00;
            for (int i = 0; i < 2; i++) db_cnt_p2[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press_p2[i] <= 1'b0;
                if (btn_p1[i] == acc_p2[i]) begin
                    db_cnt_p2[i] <= '0;
                end else if (db_cnt_p2[i] == DB_LAST) begin
                    acc_p2[i]    <= btn_p1[i];
                    db_cnt_p2[i] <= '0;
                    press_p2[i]  <= ~btn_p1[i];
                end else begin
                    db_cnt_p2[i] <= db_cnt_p2[i] + DB_W'(1);
                end
            end
        end
    end

    // ---- stage p3: sequencer state, registered decodes and prescaler
    // Sequencer and prescaler: the prescaler advances on every counting cycle
    // (including the one in which a pause lands), holds while paused and is
    // zeroed in IDLE; a wrap only emits a tick if counting continues.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_p3        <= IDLE;
            presc_p3     <= '0;
            tick         <= 1'b0;
            clear        <= 1'b0;
            running      <= 1'b0;
            display_hold <= 1'b0;
        end else begin
            st_p3        <= st_nxt;
            running      <= is_counting(st_nxt);
            display_hold <= (st_nxt == LAP);
            clear        <= (st_p3 == PAUSED) && (st_nxt == IDLE);
            tick         <= 1'b0;
            if ((st_p3 == IDLE) || (st_nxt == IDLE)) begin
                presc_p3 <= '0;
            end else if (running) begin
                if (presc_p3 == PRESC_LAST) begin
                    presc_p3 <= '0;
                    tick     <= is_counting(st_nxt);
                end else begin
                    presc_p3 <= presc_p3 + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Testbench for stopwatch_controller: directed scenarios plus a randomized
// press phase, compared every cycle against a behavioural reference model.
module tb_stopwatch_controller;

    localparam int CLK_DIV = 10;
    localparam int DB      = 4;
    localparam int SP_NEXT  [4] = '{1, 2, 1, 2};
    localparam int LAP_NEXT [4] = '{0, 3, 0, 1};

    logic       clk;
    logic       reset;
    logic       sp_raw;
    logic       lap_raw;
    logic       tick;
    logic       clear;
    logic       running;
    logic       display_hold;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tick_q [$];
    int clear_cnt, clear_cyc, chg_cnt, chg_cyc;

    // Reference model state
    int m_state, m_el;
    bit m_tick, m_clear;
    bit m_acc [2];
    int m_run [2];
    bit m_dly_sp [3];
    bit m_dly_lap [3];

    stopwatch_controller #(
        .CLK_DIV(CLK_DIV),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(4),
        .DB_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_pause(sp_raw),
        .lap_clear(lap_raw),
        .tick(tick),
        .clear(clear),
        .running(running),
        .display_hold(display_hold),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_el    = 0;
        m_tick  = 0;
        m_clear = 0;
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 1;
            m_run[i] = 0;
        end
        for (int i = 0; i < 3; i++) begin
            m_dly_sp[i]  = 0;
            m_dly_lap[i] = 0;
        end
    endtask

    // One clock edge of the behavioural model, given the raw levels sampled there.
    task automatic model_edge(input bit r_sp, input bit r_lap);
        int nxt;
        bit was_run, will_run;
        bit raw [2];
        bit fresh [2];
        nxt = m_state;
        if (m_dly_sp[2]) nxt = SP_NEXT[m_state];
        else if (m_dly_lap[2]) nxt = LAP_NEXT[m_state];
        was_run  = (m_state == 1) || (m_state == 3);
        will_run = (nxt == 1) || (nxt == 3);
        m_tick  = 0;
        m_clear = (m_state == 2) && (nxt == 0);
        if (nxt == 0) begin
            m_el = 0;
        end else if (was_run) begin
            m_el++;
            if (m_el == CLK_DIV) begin
                m_el   = 0;
                m_tick = will_run;
            end
        end
        m_state = nxt;
        raw[0] = r_sp;
        raw[1] = r_lap;
        for (int i = 0; i < 2; i++) begin
            fresh[i] = 0;
            if (raw[i] == m_acc[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_acc[i] = raw[i];
                    m_run[i] = 0;
                    fresh[i] = !raw[i];
                end
            end
        end
        m_dly_sp[2]  = m_dly_sp[1];
        m_dly_sp[1]  = m_dly_sp[0];
        m_dly_sp[0]  = fresh[0];
        m_dly_lap[2] = m_dly_lap[1];
        m_dly_lap[1] = m_dly_lap[0];
        m_dly_lap[0] = fresh[1];
    endtask

    task automatic step();
        logic [1:0] prev_state;
        prev_state = state;
        @(posedge clk);
        cyc++;
        model_edge(sp_raw, lap_raw);
        #1;
        check("cyc_state", 32'(state), 32'(m_state));
        check("cyc_tick", 32'(tick), 32'(m_tick));
        check("cyc_clear", 32'(clear), 32'(m_clear));
        check("cyc_running", 32'(running), 32'((m_state == 1) || (m_state == 3)));
        check("cyc_hold", 32'(display_hold), 32'(m_state == 3));
        if (tick) tick_q.push_back(cyc);
        if (clear) begin
            clear_cnt++;
            clear_cyc = cyc;
        end
        if (state != prev_state) begin
            chg_cnt++;
            chg_cyc = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold a button low for 'hold' cycles; returns the first sampling edge.
    task automatic press(input int which, input int hold, output int first);
        first = cyc + 1;
        if (which != 1) sp_raw = 1'b0;
        if (which != 0) lap_raw = 1'b0;
        run(hold);
        sp_raw  = 1'b1;
        lap_raw = 1'b1;
    endtask

    task automatic do_reset(input int n);
        reset   = 1'b0;
        sp_raw  = 1'b1;
        lap_raw = 1'b1;
        model_reset();
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_clear", 32'(clear), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_hold", 32'(display_hold), 32'd0);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1 reset = 1'b1;
    endtask

    initial begin
        int p, e, pz, r, kind, hold, gap;
        clear_cnt = 0;
        clear_cyc = 0;
        chg_cnt   = 0;
        chg_cyc   = 0;

        // Reset and quiet idle
        do_reset(3);
        run(100);
        check("t1_no_tick", 32'(tick_q.size()), 32'd0);

        // Long start press from IDLE
        chg_cnt = 0;
        press(0, 20, p);
        check("t2_entry_edge", 32'(chg_cyc), 32'(p + 6));
        e = p + 6;
        run(40);
        check("t2_state", 32'(state), 32'd1);
        check("t2_one_transition", 32'(chg_cnt), 32'd1);
        check("t2_tick_count", 32'(tick_q.size()), 32'd5);
        check("t2_tick0", 32'(tick_q.size() > 0 ? tick_q[0] : -1), 32'(e + 10));
        check("t2_tick1", 32'(tick_q.size() > 1 ? tick_q[1] : -1), 32'(e + 20));
        check("t2_tick2", 32'(tick_q.size() > 2 ? tick_q[2] : -1), 32'(e + 30));

        // Pause, then lap from PAUSED clears back to IDLE
        press(0, 6, p);
        run(10);
        check("t5_paused", 32'(state), 32'd2);
        tick_q.delete();
        clear_cnt = 0;
        press(1, 6, p);
        run(10);
        check("t5_idle", 32'(state), 32'd0);
        check("t5_clear_count", 32'(clear_cnt), 32'd1);
        check("t5_clear_with_change", 32'(clear_cyc), 32'(chg_cyc));
        check("t5_no_tick", 32'(tick_q.size()), 32'd0);

        // Pause 23 cycles after entry, resume later
        press(0, 6, p);
        e = p + 6;
        run(17);
        press(0, 6, p);
        run(4);
        pz = e + 23;
        check("t3_pause_edge", 32'(chg_cyc), 32'(pz));
        check("t3_paused", 32'(state), 32'd2);
        check("t3_ticks_before", 32'(tick_q.size()), 32'd2);
        run(47);
        check("t3_none_paused", 32'(tick_q.size()), 32'd2);
        press(0, 6, p);
        r = p + 6;
        run(10);
        check("t3_resume_edge", 32'(chg_cyc), 32'(r));
        check("t3_resume_tick", 32'(tick_q.size() > 2 ? tick_q[2] : -1), 32'(r + 7));

        // Lap then lap again while counting
        press(1, 6, p);
        run(5);
        check("t4_lap_state", 32'(state), 32'd3);
        check("t4_lap_hold", 32'(display_hold), 32'd1);
        check("t4_lap_running", 32'(running), 32'd1);
        press(1, 6, p);
        run(5);
        check("t4_back_state", 32'(state), 32'd1);
        check("t4_back_hold", 32'(display_hold), 32'd0);
        run(30);
        check("t4_tick_total", 32'(tick_q.size()), 32'd8);
        for (int i = 3; i < tick_q.size(); i++)
            check("t4_tick_period", 32'(tick_q[i] - tick_q[i-1]), 32'(CLK_DIV));

        // Short glitch on lap_clear while counting
        chg_cnt = 0;
        lap_raw = 1'b0;
        run(3);
        lap_raw = 1'b1;
        run(15);
        check("t5_glitch_state", 32'(state), 32'd1);
        check("t5_glitch_nochange", 32'(chg_cnt), 32'd0);

        // Randomized presses against the model
        for (int k = 0; k < 30; k++) begin
            kind = int'($urandom_range(0, 2));
            hold = int'($urandom_range(1, 10));
            gap  = int'($urandom_range(4, 25));
            press(kind, hold, p);
            run(gap);
        end

        // Simultaneous presses while RUNNING, then reset mid-debounce
        do_reset(2);
        press(0, 6, p);
        run(10);
        check("t6_running", 32'(state), 32'd1);
        press(2, 6, p);
        run(10);
        check("t6_sp_wins", 32'(state), 32'd2);
        run(20);
        check("t6_lap_ignored", 32'(state), 32'd2);
        sp_raw = 1'b0;
        run(2);
        do_reset(2);
        chg_cnt = 0;
        run(30);
        check("t6_after_reset_state", 32'(state), 32'd0);
        check("t6_no_event", 32'(chg_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
